muldiv_seq: RTL and testbench

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/pipeline_pkg.sv | 25 ++
 rtl/muldiv_step.sv | 30 +++
 rtl/muldiv_seq.sv | 160 ++++++++++++++++
 tb/tb_muldiv_seq.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline types: data width, M-extension op codes, mul/div FSM states
package pipeline;

  localparam int XLEN = 32;

  // Encodings match funct3 of the RISC-V M extension, so decode can cast directly.
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_CALC,
    MD_SIGN,
    MD_DONE
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one radix-2 iteration: shift-add multiply or restoring shift-subtract divide
module muldiv_step
  import pipeline::*;
#(
  parameter int XLEN = pipeline::XLEN
) (
  input  logic              div_i,
  input  logic [XLEN-1:0]   operand_i,
  input  logic [2*XLEN-1:0] acc_i,
  output logic [2*XLEN-1:0] acc_o
);

  // acc_i is {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide.
  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;

  always_comb begin
    sum     = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, operand_i} : '0);
    shifted = acc_i[2*XLEN-1:XLEN-1];
    trial   = shifted - {1'b0, operand_i};
    if (div_i) begin
      if (trial[XLEN]) acc_o = {shifted[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
      else             acc_o = {trial[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
    end else begin
      acc_o = {sum, acc_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - sequential RISC-V M-extension multiply/divide unit with valid/ready handshakes
module muldiv_seq
  import pipeline::*;
#(
  parameter int XLEN = pipeline::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operand_1,
  input  logic [XLEN-1:0] operand_2,
  output logic            result_valid,
  input  logic            result_ready,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e     state_q, state_d;
  muldiv_op_e        op_q, op_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic              valid_q, valid_d;

  muldiv_op_e        op_in;
  logic              sgn1, sgn2, neg_in, div_in, div_zero, div_ovf, op_is_div;
  logic [XLEN-1:0]   mag1, mag2, special_res, quo_fix, rem_fix, sign_word;
  logic [2*XLEN-1:0] step_acc, prod_fix;

  assign op_in     = muldiv_op_e'(funct3);
  assign div_in    = funct3[2];
  assign op_is_div = op_q inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};

  always_comb begin
    sgn1 = 1'b0;
    sgn2 = 1'b0;
    unique case (op_in)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
        sgn1 = operand_1[XLEN-1];
        sgn2 = operand_2[XLEN-1];
      end
      OP_MULHSU: sgn1 = operand_1[XLEN-1];
      default: ;
    endcase
  end

  assign mag1     = sgn1 ? -operand_1 : operand_1;
  assign mag2     = sgn2 ? -operand_2 : operand_2;
  assign neg_in   = (op_in == OP_REM) ? sgn1 : (sgn1 ^ sgn2);
  assign div_zero = div_in && (operand_2 == '0);
  assign div_ovf  = (op_in == OP_DIV || op_in == OP_REM) && (operand_1 == MIN_NEG) && (&operand_2);

  // funct3[1] separates REM/REMU from DIV/DIVU within the divide group.
  always_comb begin
    if (div_zero) special_res = funct3[1] ? operand_1 : '1;
    else          special_res = funct3[1] ? '0 : MIN_NEG;
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .div_i     (op_is_div),
    .operand_i (opnd_q),
    .acc_i     (acc_q),
    .acc_o     (step_acc)
  );

  always_comb begin
    prod_fix = neg_q ? -acc_q : acc_q;
    quo_fix  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    unique case (op_q)
      OP_MUL:                      sign_word = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: sign_word = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             sign_word = quo_fix;
      default:                     sign_word = rem_fix;
    endcase
  end

  assign start_ready  = (state_q == MD_IDLE) && !flush;
  assign result_valid = valid_q;
  assign result       = valid_q ? res_q : '0;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    res_d   = res_q;
    valid_d = valid_q;
    unique case (state_q)
      MD_IDLE: begin
        if (start_valid && start_ready) begin
          op_d  = op_in;
          neg_d = neg_in;
          cnt_d = '0;
          if (div_zero || div_ovf) begin
            res_d   = special_res;
            state_d = MD_DONE;
          end else begin
            opnd_d  = div_in ? mag2 : mag1;
            acc_d   = {{XLEN{1'b0}}, div_in ? mag1 : mag2};
            state_d = MD_CALC;
          end
        end
      end
      MD_CALC: begin
        acc_d = step_acc;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = MD_SIGN;
      end
      MD_SIGN: begin
        res_d   = sign_word;
        state_d = MD_DONE;
      end
      default: begin
        // result_valid rises one cycle after DONE is entered and drops on the handshake edge.
        if (valid_q && result_ready) begin
          valid_d = 1'b0;
          state_d = MD_IDLE;
        end else begin
          valid_d = 1'b1;
        end
      end
    endcase
    if (flush) begin
      state_d = MD_IDLE;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      op_q    <= OP_MUL;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      opnd_q  <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - scoreboard bench for muldiv_seq against a RISC-V M arithmetic model
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        start_valid = 1'b0;
  logic        start_ready;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] operand_1 = '0;
  logic [31:0] operand_2 = '0;
  logic        result_valid;
  logic        result_ready = 1'b1;
  logic [31:0] result;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  bit          bp_rand = 1'b0;
  bit          ready_hold = 1'b1;

  always #5 clk = ~clk;

  muldiv_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .funct3       (funct3),
    .operand_1    (operand_1),
    .operand_2    (operand_2),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result       (result)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint     sa, sb, ua, ub;
    logic [63:0] p;
    bit          ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'(a);
    ub  = longint'(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Sole driver of result_ready: fixed level or random backpressure.
  initial forever begin
    @(posedge clk);
    #1;
    result_ready = bp_rand ? ($urandom_range(0, 3) != 0) : ready_hold;
  end

  // Monitor: pops the scoreboard on every handshake and checks stability while stalled.
  initial begin
    logic [31:0] held;
    logic [31:0] e;
    bit          stalled;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        if (stalled && result_valid) check("hold_stable", result, held);
        stalled = result_valid && !result_ready;
        held    = result;
        if (result_valid && result_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_result: got %h, expected no result", result);
          end else begin
            e = exp_q.pop_front();
            check("result", result, e);
          end
        end
      end
    end
  end

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [31:0] exp);
    int g;
    g = 0;
    start_valid = 1'b1;
    funct3      = f;
    operand_1   = a;
    operand_2   = b;
    @(negedge clk);
    while (!start_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!start_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: start_ready 0 for %0d cycles, expected 1", g);
      start_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      start_valid = 1'b0;
      funct3      = 3'($urandom);
      operand_1   = $urandom;
      operand_2   = $urandom;
      if (push) exp_q.push_back(exp);
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
      if (result_valid) break;
    end
  endtask

  task automatic directed(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat);
    int lat;
    issue(f, a, b, 1'b1, exp);
    wait_valid(lat);
    check("latency", 32'(lat), 32'(exp_lat));
  endtask

  task automatic quiet(input int n);
    int seen;
    seen = 0;
    repeat (n) begin
      @(negedge clk);
      if (result_valid) seen++;
    end
    check("no_result", 32'(seen), 32'd0);
  endtask

  initial begin
    int lat;
    int g;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", {31'b0, result_valid}, 32'd0);
    check("reset_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_start_ready", {31'b0, start_ready}, 32'd1);
    @(posedge clk);
    #1;

    directed(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34);
    directed(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    directed(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 34);
    directed(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
    directed(3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34);
    directed(3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34);
    directed(3'd5, 32'd100,       32'd7,         32'd14,        34);
    directed(3'd7, 32'd100,       32'd7,         32'd2,         34);
    directed(3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    directed(3'd6, 32'd5,         32'd0,         32'd5,         1);
    directed(3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    directed(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    directed(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);

    // Backpressure in DONE.
    ready_hold = 1'b0;
    @(posedge clk);
    #1;
    issue(3'd5, 32'd100, 32'd7, 1'b1, 32'd14);
    wait_valid(lat);
    repeat (10) begin
      @(negedge clk);
      check("bp_valid", {31'b0, result_valid}, 32'd1);
      check("bp_result", result, 32'd14);
      check("bp_start_ready", {31'b0, start_ready}, 32'd0);
    end
    ready_hold = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("bp_release_valid", {31'b0, result_valid}, 32'd0);
    check("bp_release_idle", {31'b0, start_ready}, 32'd1);

    // Flush in CALC cycle 17.
    issue(3'd0, 32'd1234, 32'd5678, 1'b0, 32'd0);
    repeat (16) @(posedge clk);
    #1;
    flush = 1'b1;
    #1;
    check("flush_start_ready", {31'b0, start_ready}, 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    #1;
    check("flush_idle", {31'b0, start_ready}, 32'd1);
    check("flush_valid", {31'b0, result_valid}, 32'd0);
    quiet(40);

    // Flush with a request in IDLE rejects it.
    @(posedge clk);
    #1;
    flush       = 1'b1;
    start_valid = 1'b1;
    funct3      = 3'd4;
    operand_1   = 32'd5;
    operand_2   = 32'd0;
    #1;
    check("flush_reject_ready", {31'b0, start_ready}, 32'd0);
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    flush       = 1'b0;
    quiet(5);

    // Reset while the result waits in DONE.
    ready_hold = 1'b0;
    @(posedge clk);
    #1;
    issue(3'd0, 32'd3, 32'd4, 1'b0, 32'd0);
    wait_valid(lat);
    check("pre_reset_valid", {31'b0, result_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_done_valid", {31'b0, result_valid}, 32'd0);
    check("reset_done_result", result, 32'd0);
    @(negedge clk);
    rst_n      = 1'b1;
    ready_hold = 1'b1;
    quiet(40);

    // Reset mid-CALC.
    @(posedge clk);
    #1;
    issue(3'd5, 32'd1000, 32'd3, 1'b0, 32'd0);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_calc_valid", {31'b0, result_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_calc_idle", {31'b0, start_ready}, 32'd1);
    quiet(45);

    // Random back-to-back traffic with backpressure.
    bp_rand = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 1000; i++) begin
      logic [2:0]  f;
      logic [31:0] a, b;
      f = 3'($urandom);
      a = pick_operand();
      b = pick_operand();
      issue(f, a, b, 1'b1, ref_op(f, a, b));
    end
    g = 0;
    while (exp_q.size() != 0 && g < 3000) begin
      @(posedge clk);
      g++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    bp_rand = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
